// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit:
// next-PC source encodings, FSM states and default widths.
package pc_pkg;

    localparam int         PC_W_DEF    = 8;
    localparam logic [7:0] IRQ_VEC_DEF = 8'h01;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_RET    = 2'b11
    } pc_src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } irq_state_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; a push when full overwrites the
// oldest entry, a pop when empty leaves the stack untouched.
module ret_addr_stack #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PC_W-1:0]                  push_data,
    output logic [PC_W-1:0]                  top,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   count,
    output logic                             ovf,
    output logic                             unf
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_inc;
    logic [PTR_W-1:0] wptr_dec;
    logic [CNT_W-1:0] cnt_q;
    logic             full;
    logic             empty;

    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty = (cnt_q == '0);

    // wptr_q points at the slot the next push writes; when full that
    // slot holds the oldest entry, which makes overflow overwrite it.
    assign wptr_inc = (wptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0
                                                        : wptr_q + PTR_W'(1);
    assign wptr_dec = (wptr_q == '0) ? PTR_W'(RAS_DEPTH - 1)
                                     : wptr_q - PTR_W'(1);

    assign top   = mem_q[wptr_dec];
    assign count = cnt_q;
    assign ovf   = push && full;
    assign unf   = pop && empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            wptr_q <= wptr_inc;
            if (!full) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wptr_q <= wptr_dec;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with next-PC selection, call/return stack
// and a single-level interrupt entry/exit handshake.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] IRQ_VEC   = PC_W'(IRQ_VEC_DEF)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall,
    input  logic [1:0]                     pc_src,
    input  logic                           call,
    input  logic                           reti,
    input  logic [PC_W-1:0]                branch_addr,
    input  logic [PC_W-1:0]                jump_addr,
    input  logic [PC_W-1:0]                ret_addr,
    input  logic                           irq_req,
    output logic                           irq_ack,
    output logic [PC_W-1:0]                pc,
    output logic [PC_W-1:0]                pc_plus1,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_ovf,
    output logic                           ras_unf,
    output logic                           in_isr
);

    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    irq_state_e       state_q;
    irq_state_e       state_d;
    logic             ack_q;
    logic             ack_d;
    logic             ovf_q;
    logic             unf_q;

    logic             push;
    logic             pop;
    logic [PC_W-1:0]  push_data;
    logic [PC_W-1:0]  ras_top;
    logic [CNT_W-1:0] ras_cnt;
    logic             ras_ovf_c;
    logic             ras_unf_c;
    logic             irq_take;

    assign pc_plus1 = pc_q + PC_W'(1);
    assign irq_take = irq_req && (state_q == ST_IDLE) && !stall;

    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        ack_d     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = pc_plus1;
        if (!stall) begin
            if (irq_take) begin
                // The instruction at pc is dropped and re-fetched on reti.
                push      = 1'b1;
                push_data = pc_q;
                pc_d      = IRQ_VEC;
                state_d   = ST_ISR;
                ack_d     = 1'b1;
            end else begin
                unique case (pc_src)
                    PC_SRC_SEQ: begin
                        pc_d = pc_plus1;
                    end
                    PC_SRC_BRANCH: begin
                        pc_d = branch_addr;
                    end
                    PC_SRC_JUMP: begin
                        pc_d = jump_addr;
                        push = call;
                    end
                    PC_SRC_RET: begin
                        pop  = 1'b1;
                        pc_d = (ras_cnt == '0) ? ret_addr : ras_top;
                        if (reti) begin
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            ovf_q   <= ras_ovf_c;
            unf_q   <= ras_unf_c;
        end
    end

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .top       (ras_top),
        .count     (ras_cnt),
        .ovf       (ras_ovf_c),
        .unf       (ras_unf_c)
    );

    assign pc        = pc_q;
    assign ras_count = ras_cnt;
    assign in_isr    = (state_q == ST_ISR);
    assign irq_ack   = ack_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequencing, wrap, stall, calls,
// stack overflow/underflow, interrupt entry/exit and reset mid-ISR.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       stall;
    logic [1:0] pc_src;
    logic       call;
    logic       reti;
    logic [7:0] branch_addr;
    logic [7:0] jump_addr;
    logic [7:0] ret_addr;
    logic       irq_req;
    logic       irq_ack;
    logic [7:0] pc;
    logic [7:0] pc_plus1;
    logic [2:0] ras_count;
    logic       ras_ovf;
    logic       ras_unf;
    logic       in_isr;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .PC_W      (8),
        .RAS_DEPTH (4),
        .RESET_VEC (8'h00),
        .IRQ_VEC   (8'h01)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .pc_src      (pc_src),
        .call        (call),
        .reti        (reti),
        .branch_addr (branch_addr),
        .jump_addr   (jump_addr),
        .ret_addr    (ret_addr),
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .ras_count   (ras_count),
        .ras_ovf     (ras_ovf),
        .ras_unf     (ras_unf),
        .in_isr      (in_isr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        stall       = 1'b0;
        pc_src      = 2'b00;
        call        = 1'b0;
        reti        = 1'b0;
        irq_req     = 1'b0;
        branch_addr = 8'h00;
        jump_addr   = 8'h00;
        ret_addr    = 8'hAA;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        tick();
        checks++;
        if (pc !== 8'h00) begin
            errors++; $display("FAIL reset_pc got=%h exp=00", pc);
        end
        checks++;
        if (pc_plus1 !== 8'h01) begin
            errors++; $display("FAIL reset_pc_plus1 got=%h exp=01", pc_plus1);
        end
        checks++;
        if (ras_count !== 3'd0 || in_isr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cnt=%0d isr=%b exp 0 0", ras_count, in_isr);
        end
        checks++;
        if ({irq_ack, ras_ovf, ras_unf} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses got=%b exp=000", {irq_ack, ras_ovf, ras_unf});
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc !== 8'(i)) begin
                errors++; $display("FAIL seq_pc got=%h exp=%h", pc, 8'(i));
            end
        end
    endtask

    task automatic test_wrap();
        pc_src = 2'b01; branch_addr = 8'hFE;
        tick();
        checks++;
        if (pc !== 8'hFE) begin
            errors++; $display("FAIL wrap_branch got=%h exp=fe", pc);
        end
        pc_src = 2'b00;
        tick();
        checks++;
        if (pc !== 8'hFF || pc_plus1 !== 8'h00) begin
            errors++;
            $display("FAIL wrap_plus1 pc=%h p1=%h exp ff 00", pc, pc_plus1);
        end
        pc_src = 2'b10; call = 1'b1; jump_addr = 8'h50;
        tick();
        checks++;
        if (pc !== 8'h50 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL wrap_call pc=%h cnt=%0d exp 50 1", pc, ras_count);
        end
        call = 1'b0; pc_src = 2'b11;
        tick();
        checks++;
        if (pc !== 8'h00 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL wrap_ret pc=%h cnt=%0d exp 00 0", pc, ras_count);
        end
        set_idle();
    endtask

    task automatic test_branch_stall();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (pc !== 8'h05) begin
            errors++; $display("FAIL bs_start got=%h exp=05", pc);
        end
        pc_src = 2'b01; branch_addr = 8'h40;
        tick();
        checks++;
        if (pc !== 8'h40 || {irq_ack, ras_ovf, ras_unf} !== 3'b000) begin
            errors++;
            $display("FAIL bs_branch pc=%h pulses=%b exp 40 000",
                     pc, {irq_ack, ras_ovf, ras_unf});
        end
        stall = 1'b1; branch_addr = 8'h99; irq_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc !== 8'h40 || in_isr !== 1'b0 ||
                {irq_ack, ras_ovf, ras_unf} !== 3'b000) begin
                errors++;
                $display("FAIL bs_stall pc=%h isr=%b pulses=%b exp 40 0 000",
                         pc, in_isr, {irq_ack, ras_ovf, ras_unf});
            end
        end
        set_idle();
        tick();
        checks++;
        if (pc !== 8'h41) begin
            errors++; $display("FAIL bs_resume got=%h exp=41", pc);
        end
    endtask

    task automatic test_calls();
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        pc_src = 2'b10; call = 1'b1; jump_addr = 8'h20;
        tick();
        checks++;
        if (pc !== 8'h20 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL call1 pc=%h cnt=%0d exp 20 1", pc, ras_count);
        end
        jump_addr = 8'h30;
        tick();
        checks++;
        if (pc !== 8'h30 || ras_count !== 3'd2) begin
            errors++;
            $display("FAIL call2 pc=%h cnt=%0d exp 30 2", pc, ras_count);
        end
        pc_src = 2'b00;
        tick();
        checks++;
        if (pc !== 8'h31 || ras_count !== 3'd2) begin
            errors++;
            $display("FAIL stray_call pc=%h cnt=%0d exp 31 2", pc, ras_count);
        end
        call = 1'b0; pc_src = 2'b11;
        tick();
        checks++;
        if (pc !== 8'h21 || ras_count !== 3'd1) begin
            errors++;
            $display("FAIL ret1 pc=%h cnt=%0d exp 21 1", pc, ras_count);
        end
        tick();
        checks++;
        if (pc !== 8'h04 || ras_count !== 3'd0 || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL ret2 pc=%h cnt=%0d unf=%b exp 04 0 0",
                     pc, ras_count, ras_unf);
        end
        set_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pc;
        do_reset();
        pc_src = 2'b10; call = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            jump_addr = 8'(i * 16);
            tick();
            checks++;
            if (ras_count !== ((i > 4) ? 3'd4 : 3'(i)) ||
                ras_ovf !== (i == 5)) begin
                errors++;
                $display("FAIL ovf_push%0d cnt=%0d ovf=%b", i, ras_count, ras_ovf);
            end
        end
        call = 1'b0; pc_src = 2'b11; ret_addr = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            exp_pc = 8'h41 - 8'(k * 16);
            tick();
            checks++;
            if (pc !== exp_pc || ras_count !== 3'(3 - k) ||
                ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_pop%0d pc=%h exp=%h cnt=%0d unf=%b",
                         k, pc, exp_pc, ras_count, ras_unf);
            end
        end
        tick();
        checks++;
        if (pc !== 8'hAA || ras_unf !== 1'b1 || ras_count !== 3'd0) begin
            errors++;
            $display("FAIL unf_pop pc=%h unf=%b cnt=%0d exp aa 1 0",
                     pc, ras_unf, ras_count);
        end
        pc_src = 2'b00;
        tick();
        checks++;
        if (pc !== 8'hAB || ras_unf !== 1'b0) begin
            errors++;
            $display("FAIL unf_clear pc=%h unf=%b exp ab 0", pc, ras_unf);
        end
        set_idle();
    endtask

    task automatic test_irq();
        do_reset();
        pc_src = 2'b01; branch_addr = 8'h10;
        tick();
        stall = 1'b1; irq_req = 1'b1; pc_src = 2'b00;
        tick();
        checks++;
        if (pc !== 8'h10 || irq_ack !== 1'b0 || in_isr !== 1'b0) begin
            errors++;
            $display("FAIL irq_stall pc=%h ack=%b isr=%b exp 10 0 0",
                     pc, irq_ack, in_isr);
        end
        stall = 1'b0; pc_src = 2'b01; branch_addr = 8'h77;
        tick();
        checks++;
        if (pc !== 8'h01 || irq_ack !== 1'b1 || in_isr !== 1'b1 ||
            ras_count !== 3'd1) begin
            errors++;
            $display("FAIL irq_take pc=%h ack=%b isr=%b cnt=%0d exp 01 1 1 1",
                     pc, irq_ack, in_isr, ras_count);
        end
        pc_src = 2'b00;
        tick();
        checks++;
        if (pc !== 8'h02 || irq_ack !== 1'b0 || in_isr !== 1'b1) begin
            errors++;
            $display("FAIL irq_held pc=%h ack=%b isr=%b exp 02 0 1",
                     pc, irq_ack, in_isr);
        end
        pc_src = 2'b11; reti = 1'b1;
        tick();
        checks++;
        if (pc !== 8'h10 || in_isr !== 1'b0 || ras_count !== 3'd0 ||
            irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL reti pc=%h isr=%b cnt=%0d ack=%b exp 10 0 0 0",
                     pc, in_isr, ras_count, irq_ack);
        end
        pc_src = 2'b00; reti = 1'b0;
        tick();
        checks++;
        if (pc !== 8'h01 || irq_ack !== 1'b1 || in_isr !== 1'b1 ||
            ras_count !== 3'd1) begin
            errors++;
            $display("FAIL irq_retake pc=%h ack=%b isr=%b cnt=%0d exp 01 1 1 1",
                     pc, irq_ack, in_isr, ras_count);
        end
    endtask

    task automatic test_reset_mid_isr();
        irq_req = 1'b0; pc_src = 2'b10; call = 1'b1; jump_addr = 8'h60;
        tick();
        checks++;
        if (pc !== 8'h60 || ras_count !== 3'd2 || in_isr !== 1'b1) begin
            errors++;
            $display("FAIL isr_call pc=%h cnt=%0d isr=%b exp 60 2 1",
                     pc, ras_count, in_isr);
        end
        call = 1'b0; pc_src = 2'b00; rst_n = 1'b0;
        tick();
        checks++;
        if (pc !== 8'h00 || pc_plus1 !== 8'h01 || ras_count !== 3'd0 ||
            in_isr !== 1'b0) begin
            errors++;
            $display("FAIL isr_reset pc=%h p1=%h cnt=%0d isr=%b exp 00 01 0 0",
                     pc, pc_plus1, ras_count, in_isr);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (pc !== 8'h01 || in_isr !== 1'b0) begin
            errors++;
            $display("FAIL post_reset pc=%h isr=%b exp 01 0", pc, in_isr);
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_branch_stall();
        test_calls();
        test_overflow();
        test_irq();
        test_reset_mid_isr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
